pdm_tx: RTL

PDM transmitter for the lock-in path. It takes parallel unsigned samples over a valid/ready handshake and converts them to a 1-bit pulse-density stream (`pdm_pulse`) with a first-order delta-sigma modulator. It also generates the square-wave `ref_pulse`, phase-locked to the PDM bit clock. Both outputs feed the downstream XOR mixer directly and change on the same clock edge, so the mixer output is glitch-free.

---
 rtl/pdm_pkg.sv | 21 ++
 rtl/pdm_tx_if.sv | 32 +++
 rtl/pdm_tick_gen.sv | 49 ++++
 rtl/pdm_tx.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// ============================================================================
// Module      : pdm_pkg
// Description : Shared defaults and helpers for the PDM transmit/receive path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pdm_pkg;

    localparam int PDM_DATA_W   = 16;
    localparam int PDM_CLK_DIV  = 4;
    localparam int PDM_REF_HALF = 64;

    // Counter width for a modulo-n counter; a 1-bit floor keeps n == 1 legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : pdm_pkg

`default_nettype wire

// File: rtl/pdm_tx_if.sv
// ============================================================================
// Module      : pdm_tx_if
// Description : Valid/ready sample stream into the PDM transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pdm_tx_if
    import pdm_pkg::*;
#(
    parameter int DATA_W = PDM_DATA_W
) ();

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface : pdm_tx_if

`default_nettype wire

// File: rtl/pdm_tick_gen.sv
// ============================================================================
// Module      : pdm_tick_gen
// Description : Clock-enable divider producing one tick every DIV enabled clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_tick_gen
    import pdm_pkg::*;
#(
    parameter int DIV = PDM_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int               CNT_W    = cnt_width(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);
    assign tick_o  = enable_i && !clear_i && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : pdm_tick_gen

`default_nettype wire

// File: rtl/pdm_tx.sv
// ============================================================================
// Module      : pdm_tx
// Description : First-order delta-sigma PDM transmitter with phase-locked
//               reference square wave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_tx
    import pdm_pkg::*;
#(
    parameter int DATA_W   = PDM_DATA_W,
    parameter int CLK_DIV  = PDM_CLK_DIV,
    parameter int REF_HALF = PDM_REF_HALF
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     enable,
    pdm_tx_if.slave  s,
    output logic     pdm_pulse,
    output logic     ref_pulse,
    output logic     pdm_tick,
    output logic     underrun
);

    localparam int               REF_W    = cnt_width(REF_HALF);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_HALF - 1);

    logic              tick;
    logic              accept;
    logic [DATA_W-1:0] sel;
    logic [DATA_W:0]   sum;

    logic [DATA_W-1:0] hold_q,       hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] cur_q,        cur_d;
    logic [DATA_W-1:0] acc_q,        acc_d;
    logic              pdm_q,        pdm_d;
    logic              ref_q,        ref_d;
    logic [REF_W-1:0]  ref_cnt_q,    ref_cnt_d;
    logic              tick_q,       tick_d;
    logic              underrun_q,   underrun_d;

    pdm_tick_gen #(
        .DIV      (CLK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enable),
        .clear_i  (!enable),
        .tick_o   (tick)
    );

    // s_ready comes straight from the flop, so an accept can never coincide
    // with the tick that unloads a full holding register.
    assign s.s_ready = !hold_valid_q;
    assign accept    = s.s_valid && !hold_valid_q;
    assign sel       = hold_valid_q ? hold_q : cur_q;
    assign sum       = {1'b0, acc_q} + {1'b0, sel};

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        cur_d        = cur_q;
        acc_d        = acc_q;
        pdm_d        = pdm_q;
        ref_d        = ref_q;
        ref_cnt_d    = ref_cnt_q;
        tick_d       = tick;
        underrun_d   = tick && !hold_valid_q;

        if (accept) begin
            hold_d       = s.s_data;
            hold_valid_d = 1'b1;
        end

        if (tick) begin
            if (hold_valid_q) begin
                cur_d        = hold_q;
                hold_valid_d = 1'b0;
            end
            acc_d = sum[DATA_W-1:0];
            pdm_d = sum[DATA_W];
            if (ref_cnt_q == REF_LAST) begin
                ref_cnt_d = '0;
                ref_d     = !ref_q;
            end else begin
                ref_cnt_d = ref_cnt_q + 1'b1;
            end
        end

        // Stopping realigns modulator and reference phase; samples survive.
        if (!enable) begin
            acc_d     = '0;
            pdm_d     = 1'b0;
            ref_d     = 1'b0;
            ref_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            cur_q        <= '0;
            acc_q        <= '0;
            pdm_q        <= 1'b0;
            ref_q        <= 1'b0;
            ref_cnt_q    <= '0;
            tick_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            cur_q        <= cur_d;
            acc_q        <= acc_d;
            pdm_q        <= pdm_d;
            ref_q        <= ref_d;
            ref_cnt_q    <= ref_cnt_d;
            tick_q       <= tick_d;
            underrun_q   <= underrun_d;
        end
    end

    assign pdm_pulse = pdm_q;
    assign ref_pulse = ref_q;
    assign pdm_tick  = tick_q;
    assign underrun  = underrun_q;

endmodule : pdm_tx

`default_nettype wire
